mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter and input-port responder on the processor's data bus, alongside DataMemory. It decodes a 16-byte window, accepts byte stores into a transmit FIFO, serialises them as 8N1 frames on `TxD`, and answers loads with status, divisor and a synchronised copy of `PortIn`. The top level steers `ReadData` from this block whenever `Hit` is high.

---
 rtl/mmio_uart_pkg.sv | 25 ++
 rtl/tx_fifo.sv | 50 +++++
 rtl/mmio_uart_tx.sv | 183 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - shared constants and FSM encoding for the MMIO UART transmitter
package mmio_uart_pkg;

    // Word offsets within the 16-byte window, decoded from Address[3:2]
    localparam logic [1:0] TXDATA_OFF = 2'd0;
    localparam logic [1:0] STATUS_OFF = 2'd1;
    localparam logic [1:0] BAUD_OFF   = 2'd2;
    localparam logic [1:0] PORTIN_OFF = 2'd3;

    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_FULL      = 1;
    localparam int STATUS_EMPTY     = 2;
    localparam int STATUS_OVF       = 3;
    localparam int STATUS_COUNT_LSB = 4;

    localparam logic [15:0] MIN_DIVISOR = 16'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - synchronous FIFO; a push while full is accepted only alongside a pop
module tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with status, divisor and input-port registers
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = 32'h1001_0400,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        TxD,
    output logic        TxIrq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e       state, state_n;
    logic [7:0]      shift, shift_n;
    logic [15:0]     timer, timer_n;
    logic [15:0]     div_lat, div_n;
    logic [2:0]      bit_idx, bit_n;
    logic            txd, txd_n;
    logic            tx_irq;
    logic [15:0]     baud_div;
    logic            overflow;
    logic [7:0]      sync1, sync2;
    logic [1:0]      offset;
    logic            wr_txdata, wr_baud, rd_status;
    logic            pop, bit_end;
    logic [7:0]      fifo_data;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     status;
    logic            unused;

    assign unused    = ^{Address[1:0], WriteData[31:16]};
    assign Hit       = (Address[31:4] == BASE_ADDRESS[31:4]);
    assign offset    = Address[3:2];
    assign wr_txdata = Hit && MemWrite && (offset == TXDATA_OFF);
    assign wr_baud   = Hit && MemWrite && (offset == BAUD_OFF);
    assign rd_status = Hit && MemRead && (offset == STATUS_OFF);
    assign bit_end   = (timer == 16'd0);
    assign TxD       = txd;
    assign TxIrq     = tx_irq;

    tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_txdata),
        .push_data (WriteData[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shift    <= '0;
            timer    <= '0;
            div_lat  <= DEFAULT_DIVISOR;
            bit_idx  <= '0;
            txd      <= 1'b1;
            tx_irq   <= 1'b1;
            baud_div <= DEFAULT_DIVISOR;
            overflow <= 1'b0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            timer    <= timer_n;
            div_lat  <= div_n;
            bit_idx  <= bit_n;
            txd      <= txd_n;
            // FIFO cannot be popped when IDLE is the next state, so only a push can make it non-empty
            tx_irq   <= (state_n == ST_IDLE) && fifo_empty && !wr_txdata;
            if (wr_baud)
                baud_div <= (WriteData[15:0] < MIN_DIVISOR) ? MIN_DIVISOR : WriteData[15:0];
            if (wr_txdata && fifo_full && !pop)
                overflow <= 1'b1;
            else if (rd_status)
                overflow <= 1'b0;
            sync1    <= PortIn;
            sync2    <= sync1;
        end
    end

    always_comb begin
        state_n = state;
        shift_n = shift;
        timer_n = timer;
        div_n   = div_lat;
        bit_n   = bit_idx;
        txd_n   = txd;
        pop     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_data;
                    div_n   = baud_div;
                    timer_n = baud_div - 16'd1;
                    bit_n   = '0;
                    txd_n   = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    timer_n = div_lat - 16'd1;
                    txd_n   = shift[0];
                    state_n = ST_DATA;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_n = div_lat - 16'd1;
                    if (bit_idx == 3'd7) begin
                        txd_n   = 1'b1;
                        state_n = ST_STOP;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shift_n = {1'b0, shift[7:1]};
                        txd_n   = shift[1];
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_data;
                        div_n   = baud_div;
                        timer_n = baud_div - 16'd1;
                        bit_n   = '0;
                        txd_n   = 1'b0;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        status                              = '0;
        status[STATUS_BUSY]                 = (state != ST_IDLE);
        status[STATUS_FULL]                 = fifo_full;
        status[STATUS_EMPTY]                = fifo_empty;
        status[STATUS_OVF]                  = overflow;
        status[STATUS_COUNT_LSB +: 4]       = 4'(fifo_count);
    end

    always_comb begin
        ReadData = 32'd0;
        if (Hit && MemRead) begin
            case (offset)
                STATUS_OFF: ReadData = status;
                BAUD_OFF:   ReadData = {16'd0, baud_div};
                PORTIN_OFF: ReadData = {24'd0, sync2};
                default:    ReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h1001_0400;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [7:0]  port_in;
    logic [31:0] read_data;
    logic        hit;
    logic        txd;
    logic        tx_irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDRESS    (BASE),
        .FIFO_DEPTH      (4),
        .DEFAULT_DIVISOR (16'd434)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (address),
        .WriteData (write_data),
        .MemWrite  (mem_write),
        .MemRead   (mem_read),
        .PortIn    (port_in),
        .ReadData  (read_data),
        .Hit       (hit),
        .TxD       (txd),
        .TxIrq     (tx_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        address    = BASE;
        write_data = 32'd0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
    endtask

    task automatic set_write(input logic [3:0] off, input logic [31:0] d);
        address    = BASE + {28'd0, off};
        write_data = d;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
    endtask

    task automatic peek(input logic [3:0] off, output logic [31:0] d);
        address  = BASE + {28'd0, off};
        mem_read = 1'b1;
        #1;
        d        = read_data;
        mem_read = 1'b0;
    endtask

    // Checks TxD at bit-time slots first..last of a frame; slot 0 is the first start-bit cycle
    task automatic check_frame(input string tag, input logic [7:0] b, input int d,
                               input int first, input int last);
        logic exp_bit;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            if (i / d == 0)      exp_bit = 1'b0;
            else if (i / d == 9) exp_bit = 1'b1;
            else                 exp_bit = b[i / d - 1];
            chk($sformatf("%s[%0d]", tag, i), 32'(txd), 32'(exp_bit));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bus_idle();
        port_in = 8'd0;

        // reset held with random bus traffic
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            address    = BASE + 32'($urandom_range(0, 15));
            write_data = $urandom;
            mem_write  = 1'($urandom_range(0, 1));
            mem_read   = 1'($urandom_range(0, 1));
            port_in    = 8'($urandom);
        end
        @(negedge clk);
        bus_idle();
        port_in = 8'd0;
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_irq", 32'(tx_irq), 32'd1);
        peek(4'h4, rd); chk("reset_status", rd, 32'h4);
        peek(4'h8, rd); chk("reset_baud", rd, 32'd434);
        peek(4'hC, rd); chk("reset_portin", rd, 32'd0);
        reset = 1'b1;

        // single frame, divisor 4
        @(negedge clk); set_write(4'h8, 32'd4);
        @(negedge clk); set_write(4'h0, 32'h55);
        @(negedge clk); bus_idle();
        chk("store_txd", 32'(txd), 32'd1);
        chk("store_irq", 32'(tx_irq), 32'd0);
        peek(4'h4, rd); chk("store_status", rd, 32'h10);
        check_frame("f55", 8'h55, 4, 0, 39);
        chk("f55_irq_last", 32'(tx_irq), 32'd0);
        @(negedge clk);
        chk("f55_irq", 32'(tx_irq), 32'd1);
        chk("f55_idle", 32'(txd), 32'd1);

        // six consecutive stores: byte 1 popped at once, 2..5 fill the FIFO, 6 overflows
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i >= 3) chk($sformatf("b2b_start%0d", i), 32'(txd), 32'd0);
            set_write(4'h0, 32'(i));
        end
        @(negedge clk);
        bus_idle();
        address  = BASE + 32'h4;
        mem_read = 1'b1;
        #1;
        chk("b2b_status_ovf", read_data, 32'h4B);
        chk("b2b_bit0", 32'(txd), 32'd1);
        check_frame("b2b1", 8'h01, 4, 5, 39);
        peek(4'h4, rd); chk("b2b_status_clr", rd, 32'h43);
        check_frame("b2b2", 8'h02, 4, 0, 39);
        check_frame("b2b3", 8'h03, 4, 0, 39);
        check_frame("b2b4", 8'h04, 4, 0, 39);
        check_frame("b2b5", 8'h05, 4, 0, 39);
        @(negedge clk);
        chk("b2b_irq", 32'(tx_irq), 32'd1);
        peek(4'h4, rd); chk("b2b_status_end", rd, 32'h4);
        repeat (8) @(negedge clk);
        chk("b2b_no_sixth", 32'(txd), 32'd1);

        // divisor change during a frame
        @(negedge clk); set_write(4'h0, 32'h3C);
        @(negedge clk); set_write(4'h0, 32'hC3);
        @(negedge clk); chk("div_start0", 32'(txd), 32'd0); set_write(4'h8, 32'd8);
        @(negedge clk); bus_idle(); chk("div_start1", 32'(txd), 32'd0);
        peek(4'h8, rd); chk("div_baud", rd, 32'd8);
        check_frame("div3c", 8'h3C, 4, 2, 39);
        check_frame("divc3", 8'hC3, 8, 0, 79);
        @(negedge clk);
        chk("div_irq", 32'(tx_irq), 32'd1);

        // reset during data bit 3 of a frame with a second byte queued
        @(negedge clk); set_write(4'h0, 32'h37);
        @(negedge clk); set_write(4'h0, 32'hE9);
        @(negedge clk); bus_idle(); chk("rst_start", 32'(txd), 32'd0);
        check_frame("rst37", 8'h37, 8, 1, 35);
        #1 reset = 1'b0;
        #1;
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_irq", 32'(tx_irq), 32'd1);
        peek(4'h4, rd); chk("rst_status", rd, 32'h4);
        peek(4'h8, rd); chk("rst_baud", rd, 32'd434);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); set_write(4'h8, 32'd4);
        @(negedge clk); set_write(4'h0, 32'h81);
        @(negedge clk); bus_idle();
        check_frame("post_rst", 8'h81, 4, 0, 39);
        @(negedge clk);
        chk("post_rst_irq", 32'(tx_irq), 32'd1);
        peek(4'h4, rd); chk("post_rst_status", rd, 32'h4);

        // PORTIN synchroniser latency
        @(negedge clk); port_in = 8'hA5; peek(4'hC, rd); chk("portin_e0", rd, 32'd0);
        @(negedge clk); peek(4'hC, rd); chk("portin_e1", rd, 32'd0);
        @(negedge clk); peek(4'hC, rd); chk("portin_e2", rd, 32'hA5);

        // out-of-window access
        @(negedge clk);
        address    = BASE + 32'h10;
        write_data = 32'h77;
        mem_write  = 1'b1;
        mem_read   = 1'b1;
        #1;
        chk("miss_hit", 32'(hit), 32'd0);
        chk("miss_rdata", read_data, 32'd0);
        @(negedge clk);
        bus_idle();
        chk("miss_irq", 32'(tx_irq), 32'd1);
        peek(4'h4, rd); chk("miss_status", rd, 32'h4);
        peek(4'h8, rd); chk("miss_baud", rd, 32'd4);
        peek(4'h0, rd); chk("txdata_read", rd, 32'd0);
        chk("txdata_hit", 32'(hit), 32'd1);

        // STATUS write ignored, divisor clamping
        @(negedge clk); set_write(4'h4, 32'hFF);
        @(negedge clk); bus_idle();
        peek(4'h4, rd); chk("status_wr_ignored", rd, 32'h4);
        @(negedge clk); set_write(4'h8, 32'd1);
        @(negedge clk); bus_idle();
        peek(4'h8, rd); chk("baud_clamp1", rd, 32'd2);
        @(negedge clk); set_write(4'h8, 32'd5);
        @(negedge clk); set_write(4'h8, 32'd0);
        @(negedge clk); bus_idle();
        peek(4'h8, rd); chk("baud_clamp0", rd, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
